// File: rtl/reg_dump_pkg.sv
// Shared types and UART framing constants for the register dump transmitter.
package reg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    FINISH
  } state_e;

  localparam logic        UART_START_BIT = 1'b0;
  localparam logic        UART_STOP_BIT  = 1'b1;
  localparam int unsigned UART_DATA_BITS = 8;

  // Index width that stays legal when only one item exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_dump_tx_uart.sv
// 8N1 UART byte transmitter: bit timer plus 10-bit frame shifter.
// ready_c rises in the last stop-bit cycle so a new byte can follow with no idle gap.
module reg_dump_tx_uart
  import reg_dump_pkg::*;
#(
  parameter int unsigned clk_div = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       ready_c,
  output logic       tx
);

  localparam int unsigned TIMER_W = idx_width(clk_div);
  localparam int unsigned BIT_W   = idx_width(UART_DATA_BITS);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [9:0]           frame_q, frame_d;
  logic                 tx_q, tx_d;
  logic                 tick;

  assign tick    = (timer_q == '0);
  assign ready_c = (state_q == IDLE) || ((state_q == STOP) && tick);
  assign tx      = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      frame_q   <= '1;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    tx_d      = tx_q;

    if (state_q != IDLE) begin
      timer_d = tick ? TIMER_W'(clk_div - 1) : timer_q - TIMER_W'(1);
    end

    case (state_q)
      IDLE: tx_d = 1'b1;
      START: begin
        if (tick) begin
          state_d   = DATA;
          frame_d   = {1'b1, frame_q[9:1]};
          tx_d      = frame_q[1];
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          frame_d = {1'b1, frame_q[9:1]};
          tx_d    = frame_q[1];
          if (bit_idx_q == BIT_W'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A new byte overrides whatever the frame would otherwise do next.
    if (byte_valid && ready_c) begin
      state_d   = START;
      timer_d   = TIMER_W'(clk_div - 1);
      bit_idx_d = '0;
      frame_d   = {UART_STOP_BIT, byte_data, UART_START_BIT};
      tx_d      = UART_START_BIT;
    end
  end

endmodule

// File: rtl/reg_dump_tx.sv
// Walks every register through rd_sel and streams each one LSB-byte first over UART.
// Each register is snapshotted at its LOAD cycle, so later writes do not corrupt its bytes.
module reg_dump_tx
  import reg_dump_pkg::*;
#(
  parameter int unsigned bit_width = 32,
  parameter int unsigned sel_width = 5,
  parameter int unsigned clk_div   = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [sel_width-1:0] rd_sel,
  input  logic [bit_width-1:0] rd_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NBYTES   = bit_width / 8;
  localparam int unsigned BYTE_W   = idx_width(NBYTES);
  localparam int unsigned LAST_SEL = (2 ** sel_width) - 1;

  state_e               state_q, state_d;
  logic [bit_width-1:0] word_q, word_d;
  logic [BYTE_W-1:0]    byte_idx_q, byte_idx_d;
  logic [sel_width-1:0] rd_sel_q, rd_sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [BYTE_W-1:0]    next_idx;
  logic                 byte_valid_c;
  logic [7:0]           byte_data_c;
  logic                 tx_ready_c;

  assign rd_sel   = rd_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign next_idx = byte_idx_q + BYTE_W'(1);

  reg_dump_tx_uart #(
    .clk_div(clk_div)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid_c),
    .byte_data (byte_data_c),
    .ready_c   (tx_ready_c),
    .tx        (tx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      byte_idx_q <= '0;
      rd_sel_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      rd_sel_q   <= rd_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // DATA covers a register's whole byte stream; bit phases live in the UART.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    rd_sel_d     = rd_sel_q;
    byte_valid_c = 1'b0;
    byte_data_c  = 8'(word_q >> {next_idx, 3'b000});

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          rd_sel_d = '0;
        end
      end
      LOAD: begin
        word_d       = rd_data;
        byte_idx_d   = '0;
        byte_valid_c = 1'b1;
        byte_data_c  = rd_data[7:0];
        state_d      = DATA;
      end
      DATA: begin
        if (tx_ready_c) begin
          if (byte_idx_q < BYTE_W'(NBYTES - 1)) begin
            byte_idx_d   = next_idx;
            byte_valid_c = 1'b1;
          end else if (rd_sel_q < sel_width'(LAST_SEL)) begin
            rd_sel_d = rd_sel_q + sel_width'(1);
            state_d  = LOAD;
          end else begin
            rd_sel_d = '0;
            state_d  = FINISH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD) || (state_d == DATA);
    done_d = (state_d == FINISH);
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Scoreboard bench for reg_dump_tx: stimulus queues expected bytes, a UART receiver pops them.
module tb_reg_dump_tx;

  localparam int unsigned BW = 16;
  localparam int unsigned SW = 2;
  localparam int unsigned CD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] rd_sel;
  logic [BW-1:0] rd_data;
  logic          tx;
  logic          busy;
  logic          done;

  logic [BW-1:0] regs [4];
  assign rd_data = regs[rd_sel];

  reg_dump_tx #(
    .bit_width(BW),
    .sel_width(SW),
    .clk_div  (CD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .rd_sel (rd_sel),
    .rd_data(rd_data),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         rx_bytes = 0;
  int         done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART receiver: samples the centre of each bit, start bit detected on a low idle line.
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [9:0] rx_frame;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CD == CD / 2) rx_frame[(rx_cnt - CD / 2) / CD] = tx;
      if (rx_cnt == 9 * CD + CD / 2) begin
        rx_active = 1'b0;
        rx_bytes++;
        check("rx_start_bit", 32'(rx_frame[0]), 32'h0);
        check("rx_stop_bit", 32'(rx_frame[9]), 32'h1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected_byte: got 0x%0h expected none", rx_frame[8:1]);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_byte", 32'(rx_frame[8:1]), 32'(exp_b));
        end
      end
    end
  end

  task automatic push_dump(input logic [15:0] r0, input logic [15:0] r1,
                           input logic [15:0] r2, input logic [15:0] r3);
    logic [15:0] v [4];
    v[0] = r0; v[1] = r1; v[2] = r2; v[3] = r3;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(v[i][7:0]);
      exp_q.push_back(v[i][15:8]);
    end
  endtask

  task automatic preload();
    regs[0] = 16'h1234; regs[1] = 16'hABCD; regs[2] = 16'h0001; regs[3] = 16'hFFFF;
  endtask

  // mode 0: trace checks, 3: snapshot writes, 4: start pulses while busy.
  task automatic run_dump(input int mode, input logic hold, output int done_cyc);
    int cyc;
    done_cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = hold;
    cyc = 1;
    while (cyc <= 400) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (mode == 0) begin
        if (cyc == 1)   begin check("busy_c1", 32'(busy), 1); check("rdsel_c1", 32'(rd_sel), 0); check("tx_load0", 32'(tx), 1); end
        if (cyc == 2)   check("tx_first_start", 32'(tx), 0);
        if (cyc == 81)  check("rdsel_c81", 32'(rd_sel), 0);
        if (cyc == 82)  begin check("rdsel_c82", 32'(rd_sel), 1); check("tx_gap1", 32'(tx), 1); end
        if (cyc == 163) check("rdsel_c163", 32'(rd_sel), 2);
        if (cyc == 244) check("rdsel_c244", 32'(rd_sel), 3);
        if (cyc == 324) check("busy_c324", 32'(busy), 1);
      end
      if (mode == 3 && cyc == 5)   regs[0] = 16'h5555;
      if (mode == 3 && cyc == 100) regs[3] = 16'h0F0F;
      if (mode == 4 && (cyc == 10 || cyc == 200)) start = 1'b1;
      if (mode == 4 && (cyc == 11 || cyc == 201)) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (done_cyc == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end else if (mode == 0) begin
      check("busy_at_done", 32'(busy), 0);
      check("rdsel_at_done", 32'(rd_sel), 0);
    end
  endtask

  int dc;
  int d0;
  int b0;
  int c2;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    preload();
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rdsel", 32'(rd_sel), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // Full dump with timing and rd_sel trace.
    push_dump(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
    d0 = done_cnt;
    run_dump(0, 1'b0, dc);
    check("done_cycle_full", 32'(dc), 325);
    repeat (10) @(negedge clk);
    check("done_count_full", 32'(done_cnt - d0), 1);
    check("queue_empty_full", 32'(exp_q.size()), 0);

    // Snapshot behaviour.
    push_dump(16'h1234, 16'hABCD, 16'h0001, 16'h0F0F);
    run_dump(3, 1'b0, dc);
    check("done_cycle_snap", 32'(dc), 325);
    repeat (10) @(negedge clk);
    check("queue_empty_snap", 32'(exp_q.size()), 0);
    preload();

    // Start pulses while busy are ignored.
    push_dump(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
    d0 = done_cnt;
    b0 = rx_bytes;
    run_dump(4, 1'b0, dc);
    check("done_cycle_busy_start", 32'(dc), 325);
    repeat (20) @(negedge clk);
    check("done_count_busy_start", 32'(done_cnt - d0), 1);
    check("frames_busy_start", 32'(rx_bytes - b0), 8);
    check("idle_after_busy_start", 32'(busy), 0);

    // start held high: back-to-back dumps with a single IDLE cycle between.
    push_dump(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
    push_dump(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
    run_dump(5, 1'b1, dc);
    check("done_cycle_hold1", 32'(dc), 325);
    @(negedge clk);
    check("hold_idle_busy", 32'(busy), 0);
    check("hold_idle_tx", 32'(tx), 1);
    check("hold_idle_done", 32'(done), 0);
    @(negedge clk);
    check("hold_reload_busy", 32'(busy), 1);
    start = 1'b0;
    c2 = 327;
    while (c2 <= 800 && done !== 1'b1) begin
      @(negedge clk);
      c2++;
    end
    check("done_cycle_hold2", 32'(c2), 651);
    repeat (10) @(negedge clk);
    check("queue_empty_hold", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of register 1.
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    b0 = rx_bytes;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx), 1);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_rdsel", 32'(rd_sel), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_frames", 32'(rx_bytes - b0), 2);
    exp_q.delete();
    repeat (60) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_tx", 32'(tx), 1);
    check("post_rst_no_done", 32'(done_cnt - d0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
